// File: rtl/aes_io_buffer.sv
// Host-side staging and readback buffer for the AES128 core.
// Collects key/message words, launches the core and serialises the result.
module aes_io_buffer #(
  parameter int WORD_W = 32,
  parameter int WORDS  = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [WORD_W-1:0]         data_in,
  input  logic                      shift_in_message,
  input  logic                      shift_in_key,
  input  logic                      load,
  input  logic                      shift_out,
  input  logic                      CS,
  output logic [WORD_W-1:0]         data_out,
  output logic [WORD_W*WORDS-1:0]   aes_msg,
  output logic [WORD_W*WORDS-1:0]   aes_key,
  output logic                      aes_start,
  input  logic                      aes_done,
  input  logic [WORD_W*WORDS-1:0]   aes_result,
  output logic                      busy,
  output logic                      key_valid,
  output logic                      result_ready
);

  localparam int BLK_W = WORD_W * WORDS;
  localparam int CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WORDS - 1);

  logic [BLK_W-1:0] msg_stage_q, msg_stage_d;
  logic [BLK_W-1:0] key_stage_q, key_stage_d;
  logic [BLK_W-1:0] aes_msg_q, aes_msg_d;
  logic [BLK_W-1:0] aes_key_q, aes_key_d;
  logic [BLK_W-1:0] res_buf_q, res_buf_d;
  logic [BLK_W-1:0] out_sr_q, out_sr_d;
  logic [CNT_W-1:0] msg_cnt_q, msg_cnt_d;
  logic [CNT_W-1:0] key_cnt_q, key_cnt_d;
  logic             msg_full_q, msg_full_d;
  logic             key_valid_q, key_valid_d;
  logic             busy_q, busy_d;
  logic             start_q, start_d;
  logic             rdy_q, rdy_d;

  logic msg_wr;
  logic key_wr;
  logic launch;
  logic done_ok;

  // Message has priority when both write strobes collide.
  assign msg_wr  = shift_in_message;
  assign key_wr  = shift_in_key & ~shift_in_message;
  assign launch  = msg_full_q & key_valid_q & ~busy_q;
  assign done_ok = aes_done & busy_q;

  always_comb begin
    msg_stage_d = msg_stage_q;
    key_stage_d = key_stage_q;
    aes_msg_d   = aes_msg_q;
    aes_key_d   = aes_key_q;
    res_buf_d   = res_buf_q;
    out_sr_d    = out_sr_q;
    msg_cnt_d   = msg_cnt_q;
    key_cnt_d   = key_cnt_q;
    msg_full_d  = msg_full_q;
    key_valid_d = key_valid_q;
    busy_d      = busy_q;
    start_d     = 1'b0;
    rdy_d       = rdy_q;

    if (msg_wr) begin
      msg_stage_d = {msg_stage_q[BLK_W-WORD_W-1:0], data_in};
      msg_cnt_d   = (msg_cnt_q == LAST) ? '0 : msg_cnt_q + CNT_W'(1);
      msg_full_d  = (msg_cnt_q == LAST);
    end

    if (key_wr) begin
      key_stage_d = {key_stage_q[BLK_W-WORD_W-1:0], data_in};
      key_cnt_d   = (key_cnt_q == LAST) ? '0 : key_cnt_q + CNT_W'(1);
      if (key_cnt_q == '0)
        key_valid_d = 1'b0;
      if (key_cnt_q == LAST)
        key_valid_d = 1'b1;
    end

    if (launch) begin
      start_d    = 1'b1;
      busy_d     = 1'b1;
      msg_full_d = 1'b0;
      aes_msg_d  = msg_stage_q;
      aes_key_d  = key_stage_q;
    end

    if (done_ok) begin
      res_buf_d = aes_result;
      busy_d    = 1'b0;
    end

    if (load)
      out_sr_d = res_buf_q;
    else if (shift_out)
      out_sr_d = {out_sr_q[BLK_W-WORD_W-1:0], {WORD_W{1'b0}}};

    // A fresh result outranks the read-clear.
    if (load)
      rdy_d = 1'b0;
    if (done_ok)
      rdy_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      msg_stage_q <= '0;
      key_stage_q <= '0;
      aes_msg_q   <= '0;
      aes_key_q   <= '0;
      res_buf_q   <= '0;
      out_sr_q    <= '0;
      msg_cnt_q   <= '0;
      key_cnt_q   <= '0;
      msg_full_q  <= 1'b0;
      key_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      start_q     <= 1'b0;
      rdy_q       <= 1'b0;
    end else begin
      msg_stage_q <= msg_stage_d;
      key_stage_q <= key_stage_d;
      aes_msg_q   <= aes_msg_d;
      aes_key_q   <= aes_key_d;
      res_buf_q   <= res_buf_d;
      out_sr_q    <= out_sr_d;
      msg_cnt_q   <= msg_cnt_d;
      key_cnt_q   <= key_cnt_d;
      msg_full_q  <= msg_full_d;
      key_valid_q <= key_valid_d;
      busy_q      <= busy_d;
      start_q     <= start_d;
      rdy_q       <= rdy_d;
    end
  end

  assign data_out     = CS ? out_sr_q[BLK_W-1 -: WORD_W] : '0;
  assign aes_msg      = aes_msg_q;
  assign aes_key      = aes_key_q;
  assign aes_start    = start_q;
  assign busy         = busy_q;
  assign key_valid    = key_valid_q;
  assign result_ready = rdy_q;

endmodule

// File: doc/aes_io_buffer.md
# aes_io_buffer

Datapath companion to the interface FSM. It turns the FSM's `shift_in_message`, `shift_in_key`, `load`, `shift_out` and `CS` strobes into 128-bit message/key staging, a start/done handshake with the AES128 core, and word-serial readback of the ciphertext. It sits between the 32-bit host bus and the AES core.

## Interface
- `WORD_W`, default 32: host bus word width.
- `WORDS`, default 4: words per block. Block width `BLK_W = WORD_W*WORDS` (128).
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `data_in` in WORD_W: host write word.
- `shift_in_message` in 1: write `data_in` into the message staging register.
- `shift_in_key` in 1: write `data_in` into the key staging register.
- `load` in 1: copy the result buffer into the output shift register.
- `shift_out` in 1: advance the output shift register by one word.
- `CS` in 1: read enable; gates `data_out`.
- `data_out` out WORD_W: `CS ? out_sr[BLK_W-1 -: WORD_W] : 0`.
- `aes_msg` out BLK_W: message shadow, stable while `busy`.
- `aes_key` out BLK_W: key shadow, stable while `busy`.
- `aes_start` out 1: single-cycle, registered start pulse to the core.
- `aes_done` in 1: core completion strobe, sampled only while `busy`.
- `aes_result` in BLK_W: ciphertext, valid when `aes_done` is high.
- `busy` out 1: encryption in progress.
- `key_valid` out 1: a complete key is staged.
- `result_ready` out 1: unread result is in the result buffer.

## Operation
- Staging order:
  - Each write does `reg <= {reg[BLK_W-WORD_W-1:0], data_in}`.
  - The first word ends up in `[127:96]`.
  - Separate 2-bit counters `msg_cnt` and `key_cnt` wrap modulo WORDS.
- Message write:
  - Any `shift_in_message` clears `msg_full`.
  - The write with `msg_cnt==WORDS-1` sets `msg_full` instead.
- Key write:
  - The write with `key_cnt==0` clears `key_valid`.
  - The write with `key_cnt==WORDS-1` sets `key_valid`.
- `shift_in_message` and `shift_in_key` both high in one cycle: message is written, key is ignored (`key_cnt` unchanged).
- Start condition: `msg_full & key_valid & !busy` registered high. At the next edge:
  - `aes_start<=1` for one cycle;
  - `busy<=1`;
  - `msg_full<=0`;
  - `aes_msg<=msg_stage` and `aes_key<=key_stage`.
- Staging writes while `busy` are allowed. They never disturb `aes_msg`/`aes_key`. A new complete message starts the next encryption after `busy` falls.
- `aes_done` while `busy`:
  - `res_buf<=aes_result`, `busy<=0`, `result_ready<=1`.
  - A later result overwrites `res_buf` unconditionally.
- `aes_done` while `!busy`: ignored.
- `load`:
  - `out_sr<=res_buf` and `result_ready<=0`.
  - `load` while `!result_ready` still copies the stale `res_buf`.
- `shift_out` (no `load`): `out_sr<={out_sr[BLK_W-WORD_W-1:0], WORD_W'b0}`.
- `load` and `shift_out` in the same cycle: `load` wins.
- `aes_done` and `load` in the same cycle:
  - `out_sr` receives the old `res_buf`.
  - `res_buf` takes the new result.
  - `result_ready` ends at 1 (set wins).
- `key_valid` persists across encryptions. One key serves many messages.

## Timing
- Reset: all registers, counters and outputs are 0, including `data_out`, `aes_start`, `busy`, `key_valid` and `result_ready`.
- Reset mid-operation returns everything to 0 immediately. Partial writes are discarded, and any in-flight `aes_done` is ignored until the next start.
- Write latency:
  - With the 4th message word captured at edge E (key valid, idle), `msg_full=1` after E.
  - `aes_start` and `busy` are 1 after E+1.
  - `aes_start` is 0 after E+2.
- Done: `result_ready=1` and `busy=0` one edge after `aes_done` is sampled high.
- Read sequence from the FSM:
  - One cycle of `load`, then four cycles of `CS&shift_out`.
  - `data_out` shows word0..word3 (`[127:96]` first) in those four cycles.
  - `data_out` is 0 when `CS=0`.
- Back-to-back: `aes_done` at edge D with `msg_full&key_valid` pending gives `busy=0` after D and `aes_start=1` after D+1 (one idle cycle).

## Test plan
- **Key then message.** Write key 000102..0F, then message 00112233..FF, as four words each. Required:
  - `aes_key`=000102030405060708090A0B0C0D0E0F;
  - `aes_msg`=00112233445566778899AABBCCDDEEFF;
  - `aes_start` is a one-cycle pulse two edges after the last message word;
  - `busy`=1.
- **Message before key.** Write four message words, then four key words. Required: no `aes_start` until the 4th key word; `aes_start` one edge after `key_valid` rises.
- **Done and readback.**
  - Drive `aes_done` with `aes_result`=69C4E0D86A7B0430D8CDB78070B4C55A; then `busy`=0 and `result_ready`=1.
  - Drive `load` then four `CS&shift_out` cycles; `data_out`=69C4E0D8, 6A7B0430, D8CDB780, 70B4C55A.
  - `result_ready` is 0 after `load`.
  - `data_out`=0 when `CS=0`.
- **Writes while busy.** With `busy`=1, write a new message and a new key. Required:
  - `aes_msg`/`aes_key` unchanged until `aes_done`;
  - `aes_start` fires exactly one cycle after `busy` falls.
- **Partial key rewrite.** Write two words of a new key. Required: `key_valid`=0; writing a full message produces no start.
- **Corner cases.**
  - `aes_done` and `load` together: `out_sr` gets the old result and `result_ready`=1.
  - Stray `aes_done` while idle: no state change.
  - `reset` asserted mid key write: all outputs 0 and counters restart at word 0.
